mem_port_arbiter: RTL and testbench

Shares the single data-memory port between three requesters: instruction fetch, load/store, and stack push/pop.
Every access is serialised through one issue/wait state machine, so memory sees at most one transaction in flight.
Sits between the control unit's fetch/mem_read/mem_write/SP address paths and the memory block.
Returns read data and a one-cycle completion pulse to whichever requester was granted.

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one data-memory port between fetch, load/store and stack requesters.
// Latency: req sampled at edge N, strobe in the following cycle, ack pulses MEM_LATENCY edges later.
// Backpressure: one access in flight; requests are only sampled in IDLE and must be held until ack.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (rotating priority instead of stack > data > fetch).
module mem_port_arbiter #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 20,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   input  logic              s_req,
   input  logic              s_we,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_wdata,
   output logic              s_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_F    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;
   localparam logic [1:0] OWN_S    = 2'd3;

   localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);

   // The latency counter is 3 bits wide, so anything outside 1..7 cannot be represented.
   generate
      if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
         $error("mem_port_arbiter: MEM_LATENCY must be in 1..7");
      end
   endgenerate

   logic [0:0]        state;
   logic [1:0]        owner;
   logic [2:0]        cnt;
   logic              cur_we;

   logic              any_req;
   logic              grant;
   logic              last_edge;
   logic [1:0]        win_sel;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   assign any_req   = f_req | d_req | s_req;
   assign grant     = (state == ST_IDLE) && any_req;
   assign last_edge = (state == ST_ACCESS) && (cnt == 3'd1);
   assign busy      = (state != ST_IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // rr_ptr names the requester with highest priority for the next grant.
   logic [1:0] rr_ptr;

   // Rotating choice: scan fetch -> data -> stack starting at rr_ptr.
   always_comb begin
      win_sel = OWN_NONE;
      case (rr_ptr)
         OWN_D: begin
            if (d_req)      win_sel = OWN_D;
            else if (s_req) win_sel = OWN_S;
            else if (f_req) win_sel = OWN_F;
         end
         OWN_S: begin
            if (s_req)      win_sel = OWN_S;
            else if (f_req) win_sel = OWN_F;
            else if (d_req) win_sel = OWN_D;
         end
         default: begin
            if (f_req)      win_sel = OWN_F;
            else if (d_req) win_sel = OWN_D;
            else if (s_req) win_sel = OWN_S;
         end
      endcase
   end

   // Move the pointer to the requester after the winner on every grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= OWN_F;
      end else if (grant) begin
         case (win_sel)
            OWN_F:   rr_ptr <= OWN_D;
            OWN_D:   rr_ptr <= OWN_S;
            default: rr_ptr <= OWN_F;
         endcase
      end
   end
`else
   // Fixed priority: a stack op always beats a load/store, which beats a fetch.
   always_comb begin
      win_sel = OWN_NONE;
      if (s_req)      win_sel = OWN_S;
      else if (d_req) win_sel = OWN_D;
      else if (f_req) win_sel = OWN_F;
   end
`endif

   // Steer the winner's address, direction and write data; fetch is always a read.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_we    = 1'b0;
      case (win_sel)
         OWN_F: begin
            win_addr = f_addr;
         end
         OWN_D: begin
            win_addr  = d_addr;
            win_wdata = d_wdata;
            win_we    = d_we;
         end
         OWN_S: begin
            win_addr  = s_addr;
            win_wdata = s_wdata;
            win_we    = s_we;
         end
         default: ;
      endcase
   end

   // Issue/wait state machine: IDLE grants, ACCESS counts down the memory latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         owner <= OWN_NONE;
         cnt   <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state <= ST_ACCESS;
                  owner <= win_sel;
                  cnt   <= LAT_INIT;
               end
            end
            ST_ACCESS: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state <= ST_IDLE;
                  owner <= OWN_NONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               owner <= OWN_NONE;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

   // Capture the granted request once; address and data stay put for the whole access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         cur_we    <= 1'b0;
      end else if (grant) begin
         mem_addr  <= win_addr;
         mem_wdata <= win_wdata;
         cur_we    <= win_we;
      end
   end

   // Strobes are high only in the first ACCESS cycle, i.e. the cycle right after the grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         mem_read  <= grant & ~win_we;
         mem_write <= grant &  win_we;
      end
   end

   // Completion: one-cycle ack to the owner; read data is registered, writes leave rdata alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_ack <= 1'b0;
         d_ack <= 1'b0;
         s_ack <= 1'b0;
         rdata <= '0;
      end else begin
         f_ack <= last_edge && (owner == OWN_F);
         d_ack <= last_edge && (owner == OWN_D);
         s_ack <= last_edge && (owner == OWN_S);
         if (last_edge && !cur_we) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester drivers, a transaction-level reference model
// feeding a scoreboard queue, and a negedge monitor that checks strobes, busy and acks.
module tb_mem_port_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 20;
   localparam int LAT = 3;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } op_t;

   typedef struct {
      int            who;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            sedge;
      int            aedge;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          f_req, d_req, s_req, d_we, s_we;
   logic [AW-1:0] f_addr, d_addr, s_addr;
   logic [DW-1:0] d_wdata, s_wdata;
   logic          f_ack, d_ack, s_ack;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_read, mem_write;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   op_t  fq[$], dq[$], sq[$];
   exp_t sb[$];
   int   ack_log[$];
   int   ack_cyc[$];

   int       checks = 0;
   int       errors = 0;
   int       cyc = 0;
   int       m_free = 0;
   int       wr_strobes = 0;
   int       busy_cycles = 0;
   logic [DW-1:0] m_rdata = '0;
   logic [2:0] granted = '0;
   logic [2:0] active = '0;
   logic       rand_gap = 1'b0;
   logic       rand_drop = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   int       rr = 0;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_ack(s_ack),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Memory block: address is held through ACCESS, so a combinational read is valid at capture.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic op_t rand_op();
      op_t o;
      o.we    = 1'($urandom_range(0, 1));
      o.addr  = AW'($urandom);
      o.wdata = DW'($urandom);
      return o;
   endfunction

   function automatic int qsize(input int r);
      case (r)
         0:       return fq.size();
         1:       return dq.size();
         default: return sq.size();
      endcase
   endfunction

   function automatic op_t qpop(input int r);
      case (r)
         0:       return fq.pop_front();
         1:       return dq.pop_front();
         default: return sq.pop_front();
      endcase
   endfunction

   task automatic drive(input int r, input logic req, input op_t o);
      case (r)
         0: begin f_req = req; f_addr = o.addr; end
         1: begin d_req = req; d_we = o.we; d_addr = o.addr; d_wdata = o.wdata; end
         default: begin s_req = req; s_we = o.we; s_addr = o.addr; s_wdata = o.wdata; end
      endcase
   endtask

   // Reference model: one transaction per LAT+1 cycles, winner chosen by the priority rule.
   always @(posedge clk) begin
      exp_t e;
      int w;
      logic [2:0] rq;
      cyc = cyc + 1;
      rq = {s_req, d_req, f_req};
      if (!rst && cyc >= m_free && rq != 3'b000) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         w = -1;
         for (int i = 0; i < 3; i++) begin
            if (w < 0 && rq[(rr + i) % 3]) w = (rr + i) % 3;
         end
         rr = (w + 1) % 3;
`else
         w = rq[2] ? 2 : (rq[1] ? 1 : 0);
`endif
         e.who = w;
         case (w)
            0:       begin e.we = 1'b0; e.addr = f_addr; e.wdata = '0; end
            1:       begin e.we = d_we; e.addr = d_addr; e.wdata = d_wdata; end
            default: begin e.we = s_we; e.addr = s_addr; e.wdata = s_wdata; end
         endcase
         if (e.we) ref_mem[e.addr] = e.wdata;
         else      m_rdata = ref_mem[e.addr];
         e.rdata = m_rdata;
         e.sedge = cyc;
         e.aedge = cyc + LAT;
         m_free  = cyc + LAT + 1;
         granted[w] = 1'b1;
         sb.push_back(e);
      end
   end

   // Reset abandons the in-flight transaction and clears everything the model tracks.
   always @(posedge rst) begin
      sb.delete();
      m_free  = 0;
      m_rdata = '0;
      granted = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr = 0;
`endif
   end

   // Requester drivers: hold each op until its ack, then load the next one or drop req.
   initial begin
      logic [2:0] ackv;
      op_t o;
      forever begin
         @(negedge clk);
         ackv = {s_ack, d_ack, f_ack};
         for (int r = 0; r < 3; r++) begin
            if (active[r] && ackv[r]) begin
               active[r]  = 1'b0;
               granted[r] = 1'b0;
            end
            if (!active[r]) begin
               if (qsize(r) > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
                  o = qpop(r);
                  drive(r, 1'b1, o);
                  active[r] = 1'b1;
               end else begin
                  o = rand_op();
                  drive(r, 1'b0, o);
               end
            end else if (rand_drop && granted[r] && $urandom_range(0, 3) == 0) begin
               o = rand_op();
               drive(r, 1'b0, o);
            end
         end
      end
   end

   // Monitor: pops the scoreboard when the ack is due, checks strobes and busy every cycle.
   initial begin
      logic [2:0] acks;
      logic have, exp_busy;
      forever begin
         @(negedge clk);
         acks     = {s_ack, d_ack, f_ack};
         have     = (sb.size() > 0);
         exp_busy = have && cyc >= sb[0].sedge && cyc < sb[0].aedge;
         check("busy", busy, exp_busy);
         if (busy) busy_cycles++;
         if (exp_busy) check("mem_addr_held", mem_addr, sb[0].addr);
         if (have && cyc == sb[0].sedge) begin
            check("mem_read", mem_read, !sb[0].we);
            check("mem_write", mem_write, sb[0].we);
            if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
            if (mem_write) wr_strobes++;
         end else begin
            check("strobe_idle", {mem_read, mem_write}, 0);
         end
         if (have && cyc == sb[0].aedge) begin
            check("ack_vec", acks, 32'd1 << sb[0].who);
            check("rdata", rdata, sb[0].rdata);
            ack_log.push_back(sb[0].who);
            ack_cyc.push_back(cyc);
            void'(sb.pop_front());
         end else begin
            check("no_ack", acks, 0);
         end
      end
   end

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (fq.size() + dq.size() + sq.size() != 0 || active != 3'b000 || sb.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: timeout with %0d pending expected", tag, sb.size());
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_f_ack"}, f_ack, 0);
      check({tag, "_d_ack"}, d_ack, 0);
      check({tag, "_s_ack"}, s_ack, 0);
      check({tag, "_rdata"}, rdata, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_mem_read"}, mem_read, 0);
      check({tag, "_mem_write"}, mem_write, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      ack_log.delete();
      ack_cyc.delete();
      wr_strobes  = 0;
      busy_cycles = 0;
   endtask

   task automatic check_spacing(input string tag);
      for (int i = 1; i < ack_cyc.size(); i++)
         check(tag, ack_cyc[i] - ack_cyc[i-1], LAT + 1);
   endtask

   function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      op_t o;
      o.we = we; o.addr = a; o.wdata = wd;
      return o;
   endfunction

   initial begin : main
      int exp2 [3];
      int exp5 [10];
      int n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp2 = '{0, 1, 2};
      exp5 = '{0, 1, 2, 0, 1, 2, 2, 2, 2, 2};
`else
      exp2 = '{2, 1, 0};
      exp5 = '{2, 2, 2, 2, 2, 2, 1, 1, 0, 0};
`endif
      rst = 1'b1;
      f_req = 0; d_req = 0; s_req = 0; d_we = 0; s_we = 0;
      f_addr = '0; d_addr = '0; s_addr = '0; d_wdata = '0; s_wdata = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = DW'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[10'h005]     = 20'hABCDE;
      ref_mem[10'h005] = 20'hABCDE;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Single fetch read
      clear_logs();
      fq.push_back(mk(1'b0, 10'h005, '0));
      drain("t1");
      check("t1_nacks", ack_log.size(), 1);
      check("t1_who", ack_log[0], 0);
      check("t1_rdata", rdata, 20'hABCDE);

      // Three simultaneous requests
      reset_dut();
      clear_logs();
      fq.push_back(mk(1'b0, 10'h030, '0));
      dq.push_back(mk(1'b0, 10'h010, '0));
      sq.push_back(mk(1'b1, 10'h3FF, 20'h12345));
      drain("t2");
      check("t2_nacks", ack_log.size(), 3);
      for (int i = 0; i < 3; i++) check("t2_order", ack_log[i], exp2[i]);
      check_spacing("t2_spacing");
      check("t2_writes", wr_strobes, 1);
      check("t2_mem_3ff", mem[10'h3FF], 20'h12345);

      // Store with multi-cycle latency
      clear_logs();
      dq.push_back(mk(1'b1, 10'h020, 20'h00042));
      drain("t3");
      check("t3_nacks", ack_log.size(), 1);
      check("t3_busy_cycles", busy_cycles, LAT);
      check("t3_mem_020", mem[10'h020], 20'h00042);

      // Reset in the second ACCESS cycle of a fetch
      clear_logs();
      fq.push_back(mk(1'b0, 10'h0AB, '0));
      n = 0;
      while (!granted[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!granted[0]) begin
         checks++;
         errors++;
         $display("FAIL t4_grant: fetch never granted within %0d cycles", n);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero("t4_async");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drain("t4");
      check("t4_nacks", ack_log.size(), 1);
      check("t4_who", ack_log[0], 0);
      check("t4_rdata", rdata, mem[10'h0AB]);

      // Arbitration order with all requesters held high
      reset_dut();
      clear_logs();
      for (int i = 0; i < 6; i++) sq.push_back(rand_op());
      for (int i = 0; i < 2; i++) dq.push_back(rand_op());
      for (int i = 0; i < 2; i++) fq.push_back(mk(1'b0, AW'($urandom), '0));
      drain("t5");
      check("t5_nacks", ack_log.size(), 10);
      for (int i = 0; i < 10; i++)
         check("t5_order", (i < ack_log.size()) ? ack_log[i] : -1, exp5[i]);
      check_spacing("t5_spacing");

      // Fetch held through consecutive acks
      clear_logs();
      for (int i = 0; i < 3; i++) fq.push_back(mk(1'b0, AW'(10'h100 + i), '0));
      drain("t6");
      check("t6_nacks", ack_log.size(), 3);
      check_spacing("t6_spacing");
      check("t6_rdata", rdata, ref_mem[10'h102]);

      // Random traffic with gaps and requesters dropping req mid-access
      clear_logs();
      rand_gap  = 1'b1;
      rand_drop = 1'b1;
      for (int i = 0; i < 60; i++) begin
         op_t o;
         o = rand_op();
         case ($urandom_range(0, 2))
            0:       begin o.we = 1'b0; fq.push_back(o); end
            1:       dq.push_back(o);
            default: sq.push_back(o);
         endcase
      end
      drain("t7");
      check("t7_nacks", ack_log.size(), 60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
